vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_sync_gen_if.sv | 33 +++
 rtl/vga_axis_counter.sv | 60 ++++++
 rtl/vga_sync_gen.sv | 119 +++++++++++
 tb/tb_vga_sync_gen.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : Default 640x480@60 raster constants, derived totals, sync
//             windows and the shared counter/frame types.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int c_H_VISIBLE = 640;
    localparam int c_H_FRONT   = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BACK    = 48;
    localparam int c_V_VISIBLE = 480;
    localparam int c_V_FRONT   = 10;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BACK    = 33;

    localparam int c_H_TOTAL   = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;
    localparam int c_V_TOTAL   = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;

    localparam int c_HS_START  = c_H_VISIBLE + c_H_FRONT;
    localparam int c_HS_END    = c_HS_START + c_H_SYNC - 1;
    localparam int c_VS_START  = c_V_VISIBLE + c_V_FRONT;
    localparam int c_VS_END    = c_VS_START + c_V_SYNC - 1;

    localparam int c_CNT_W     = $clog2((c_H_TOTAL > c_V_TOTAL) ? c_H_TOTAL : c_V_TOTAL);
    localparam int c_FRAME_W   = 16;

    typedef logic [c_CNT_W-1:0]   cnt_t;
    typedef logic [c_FRAME_W-1:0] frame_t;

endpackage

`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
// ============================================================================
//  Module   : vga_sync_gen_if
//  Purpose  : Timing-generator signal bundle; master = generator side.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic   enable;
    logic   pix_en;
    logic   vga_hs;
    logic   vga_vs;
    logic   blank_n;
    cnt_t   draw_x;
    cnt_t   draw_y;
    logic   frame_start;
    frame_t frame_cnt;

    modport master (
        input  enable,
        output pix_en, vga_hs, vga_vs, blank_n, draw_x, draw_y, frame_start, frame_cnt
    );

    modport slave (
        output enable,
        input  pix_en, vga_hs, vga_vs, blank_n, draw_x, draw_y, frame_start, frame_cnt
    );

endinterface

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
//  Module   : vga_axis_counter
//  Purpose  : One raster axis counter; exposes next-value decodes so the
//             top can register them in step with the count.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = c_H_VISIBLE,
    parameter int FRONT   = c_H_FRONT,
    parameter int SYNC    = c_H_SYNC,
    parameter int BACK    = c_H_BACK
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_step,
    input  wire  i_clear,
    output cnt_t o_count,
    output logic o_next_sync,
    output logic o_next_visible,
    output logic o_wrap
);

    localparam int c_TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam int c_SYNC_START = VISIBLE + FRONT;
    localparam int c_SYNC_END   = c_SYNC_START + SYNC - 1;

    cnt_t r_count;
    cnt_t w_next;
    logic w_at_end;

    always_comb begin
        w_at_end = (r_count == cnt_t'(c_TOTAL - 1));
        w_next   = r_count;
        if (i_clear) begin
            w_next = '0;
        end else if (i_step) begin
            w_next = w_at_end ? '0 : r_count + 1'b1;
        end
    end

    assign o_wrap         = i_step & ~i_clear & w_at_end;
    assign o_next_sync    = (w_next >= cnt_t'(c_SYNC_START)) && (w_next <= cnt_t'(c_SYNC_END));
    assign o_next_visible = (w_next < cnt_t'(VISIBLE));
    assign o_count        = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
//  Module   : vga_sync_gen
//  Purpose  : VGA raster timing from the system clock via a pixel-enable
//             divider. Optional frame counter: VGA_SYNC_FRAME_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = c_H_VISIBLE,
    parameter int H_FRONT   = c_H_FRONT,
    parameter int H_SYNC    = c_H_SYNC,
    parameter int H_BACK    = c_H_BACK,
    parameter int V_VISIBLE = c_V_VISIBLE,
    parameter int V_FRONT   = c_V_FRONT,
    parameter int V_SYNC    = c_V_SYNC,
    parameter int V_BACK    = c_V_BACK,
    parameter int CLK_DIV   = 2,
    parameter bit SYNC_POL  = 1'b0
) (
    input  wire            clk,
    input  wire            reset,
    vga_sync_gen_if.master vif
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [c_DIV_W-1:0] r_div;
    logic r_pix_en, r_hs, r_vs, r_blank_n, r_frame_start;
    logic w_step, w_clear;
    logic w_h_wrap, w_v_wrap, w_h_sync, w_v_sync, w_h_vis, w_v_vis;
    cnt_t w_x, w_y;

    assign w_clear = ~vif.enable;
    assign w_step  = vif.enable && (r_div == c_DIV_W'(CLK_DIV - 1));

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE), .FRONT (H_FRONT), .SYNC (H_SYNC), .BACK (H_BACK)
    ) u_h_cnt (
        .clk            (clk),
        .rst            (reset),
        .i_step         (w_step),
        .i_clear        (w_clear),
        .o_count        (w_x),
        .o_next_sync    (w_h_sync),
        .o_next_visible (w_h_vis),
        .o_wrap         (w_h_wrap)
    );

    // The vertical axis advances only on a line wrap, so vsync moves with x=0.
    vga_axis_counter #(
        .VISIBLE (V_VISIBLE), .FRONT (V_FRONT), .SYNC (V_SYNC), .BACK (V_BACK)
    ) u_v_cnt (
        .clk            (clk),
        .rst            (reset),
        .i_step         (w_h_wrap),
        .i_clear        (w_clear),
        .o_count        (w_y),
        .o_next_sync    (w_v_sync),
        .o_next_visible (w_v_vis),
        .o_wrap         (w_v_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div         <= '0;
            r_pix_en      <= 1'b0;
            r_hs          <= ~SYNC_POL;
            r_vs          <= ~SYNC_POL;
            r_blank_n     <= 1'b1;
            r_frame_start <= 1'b0;
        end else if (!vif.enable) begin
            r_div         <= '0;
            r_pix_en      <= 1'b0;
            r_hs          <= ~SYNC_POL;
            r_vs          <= ~SYNC_POL;
            r_blank_n     <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_step ? '0 : r_div + 1'b1;
            r_pix_en      <= w_step;
            r_hs          <= w_h_sync ? SYNC_POL : ~SYNC_POL;
            r_vs          <= w_v_sync ? SYNC_POL : ~SYNC_POL;
            r_blank_n     <= w_h_vis & w_v_vis;
            r_frame_start <= w_v_wrap;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    frame_t r_frame_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (!vif.enable) begin
            r_frame_cnt <= '0;
        end else if (w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign vif.frame_cnt = r_frame_cnt;
`else
    assign vif.frame_cnt = '0;
`endif

    assign vif.pix_en      = r_pix_en;
    assign vif.vga_hs      = r_hs;
    assign vif.vga_vs      = r_vs;
    assign vif.blank_n     = r_blank_n;
    assign vif.draw_x      = w_x;
    assign vif.draw_y      = w_y;
    assign vif.frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
//  Module   : tb_vga_sync_gen
//  Purpose  : Self-checking bench for vga_sync_gen on two small rasters
//             (divided active-low, undivided active-high).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

    localparam int A_HV = 8, A_HF = 2, A_HS = 3, A_HB = 2;
    localparam int A_VV = 4, A_VF = 1, A_VS = 2, A_VB = 2;
    localparam int A_DIV = 2;
    localparam bit A_POL = 1'b0;
    localparam int A_FRAME_CLKS = (A_HV + A_HF + A_HS + A_HB) * (A_VV + A_VF + A_VS + A_VB) * A_DIV;

    localparam int B_HV = 5, B_HF = 1, B_HS = 2, B_HB = 1;
    localparam int B_VV = 3, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_DIV = 1;
    localparam bit B_POL = 1'b1;
    localparam int B_FRAME_CLKS = (B_HV + B_HF + B_HS + B_HB) * (B_VV + B_VF + B_VS + B_VB) * B_DIV;

    typedef struct packed {
        logic        pe;
        logic        hs;
        logic        vs;
        logic        bn;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    int   k;
    int   n_cmp = 0;
    int   n_err = 0;

    vga_sync_gen_if if0 ();
    vga_sync_gen_if if1 ();
    assign if0.enable = en;
    assign if1.enable = en;

    vga_sync_gen #(
        .H_VISIBLE (A_HV), .H_FRONT (A_HF), .H_SYNC (A_HS), .H_BACK (A_HB),
        .V_VISIBLE (A_VV), .V_FRONT (A_VF), .V_SYNC (A_VS), .V_BACK (A_VB),
        .CLK_DIV (A_DIV), .SYNC_POL (A_POL)
    ) u_dut_a (.clk (clk), .reset (rst), .vif (if0));

    vga_sync_gen #(
        .H_VISIBLE (B_HV), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
        .V_VISIBLE (B_VV), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB),
        .CLK_DIV (B_DIV), .SYNC_POL (B_POL)
    ) u_dut_b (.clk (clk), .reset (rst), .vif (if1));

    always #5 clk = ~clk;

    // Elapsed clocks since the generator was last released from reset/enable-low.
    always @(posedge clk or posedge rst) begin
        if (rst)      k <= 0;
        else if (!en) k <= 0;
        else          k <= k + 1;
    end

    obs_t act0, act1;
    always_comb act0 = {if0.pix_en, if0.vga_hs, if0.vga_vs, if0.blank_n,
                        if0.draw_x, if0.draw_y, if0.frame_start, if0.frame_cnt};
    always_comb act1 = {if1.pix_en, if1.vga_hs, if1.vga_vs, if1.blank_n,
                        if1.draw_x, if1.draw_y, if1.frame_start, if1.frame_cnt};

    function automatic obs_t model(input int kk, input int hv, input int hf, input int hs,
                                   input int hb, input int vv, input int vf, input int vs,
                                   input int vb, input int div, input bit pol);
        obs_t m;
        int ht  = hv + hf + hs + hb;
        int vt  = vv + vf + vs + vb;
        int n   = kk / div;
        int x   = n % ht;
        int y   = (n / ht) % vt;
        m.pe = (kk > 0) && (kk % div == 0);
        m.x  = 10'(x);
        m.y  = 10'(y);
        m.hs = (x >= hv + hf && x < hv + hf + hs) ? pol : ~pol;
        m.vs = (y >= vv + vf && y < vv + vf + vs) ? pol : ~pol;
        m.bn = (x < hv) && (y < vv);
        m.fs = m.pe && (n % (ht * vt) == 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        m.fc = 16'((n / (ht * vt)) % 65536);
`else
        m.fc = 16'h0000;
`endif
        return m;
    endfunction

    function automatic obs_t exp_a(input int kk);
        return model(kk, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_DIV, A_POL);
    endfunction

    function automatic obs_t exp_b(input int kk);
        return model(kk, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_DIV, B_POL);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (act0 !== exp_a(0)) begin n_err++; $display("FAIL reset_a: got %h expected %h", act0, exp_a(0)); end
        n_cmp++; if (act1 !== exp_b(0)) begin n_err++; $display("FAIL reset_b: got %h expected %h", act1, exp_b(0)); end
        n_cmp++; if ({if0.vga_hs, if0.vga_vs, if0.blank_n} !== 3'b111) begin n_err++; $display("FAIL reset_sync_a: got %b expected 111", {if0.vga_hs, if0.vga_vs, if0.blank_n}); end
        n_cmp++; if ({if1.vga_hs, if1.vga_vs, if1.blank_n} !== 3'b001) begin n_err++; $display("FAIL reset_sync_b: got %b expected 001", {if1.vga_hs, if1.vga_vs, if1.blank_n}); end
    endtask

    task automatic test_first_pix();
        #2 rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_cmp++; if (act0 !== exp_a(k)) begin n_err++; $display("FAIL first_pix_a c=%0d: got %h expected %h", c, act0, exp_a(k)); end
            n_cmp++; if (act1 !== exp_b(k)) begin n_err++; $display("FAIL first_pix_b c=%0d: got %h expected %h", c, act1, exp_b(k)); end
            if (c == 1) begin
                n_cmp++; if (if0.pix_en !== 1'b0) begin n_err++; $display("FAIL first_pix_c1_a: got %b expected 0", if0.pix_en); end
                n_cmp++; if (if1.pix_en !== 1'b1) begin n_err++; $display("FAIL first_pix_c1_b: got %b expected 1", if1.pix_en); end
            end
            if (c == 2) begin
                n_cmp++; if ({if0.pix_en, if0.draw_x} !== {1'b1, 10'd1}) begin n_err++; $display("FAIL first_pix_c2_a: got pe=%b x=%0d expected pe=1 x=1", if0.pix_en, if0.draw_x); end
            end
        end
    endtask

    task automatic test_frame();
        int fs_a = 0, fs_b = 0, hs_pix = 0, blank_pix = 0, first_fs = -1;
        @(negedge clk) en = 1'b0;
        @(negedge clk) en = 1'b1;
        for (int c = 1; c <= 3 * A_FRAME_CLKS + 5; c++) begin
            @(negedge clk);
            n_cmp++; if (act0 !== exp_a(k)) begin n_err++; $display("FAIL frame_a c=%0d: got %h expected %h", c, act0, exp_a(k)); end
            n_cmp++; if (act1 !== exp_b(k)) begin n_err++; $display("FAIL frame_b c=%0d: got %h expected %h", c, act1, exp_b(k)); end
            if (if0.frame_start === 1'b1) begin fs_a++; if (first_fs < 0) first_fs = c; end
            if (if1.frame_start === 1'b1) fs_b++;
            if (c <= (A_HV + A_HF + A_HS + A_HB) * A_DIV && if0.pix_en === 1'b1) begin
                if (if0.vga_hs === 1'b0) hs_pix++;
                if (if0.blank_n === 1'b0) blank_pix++;
            end
        end
        n_cmp++; if (hs_pix !== A_HS) begin n_err++; $display("FAIL line_hs_width: got %0d expected %0d", hs_pix, A_HS); end
        n_cmp++; if (blank_pix !== A_HF + A_HS + A_HB) begin n_err++; $display("FAIL line_blank_width: got %0d expected %0d", blank_pix, A_HF + A_HS + A_HB); end
        n_cmp++; if (first_fs !== A_FRAME_CLKS) begin n_err++; $display("FAIL frame_period: got %0d expected %0d", first_fs, A_FRAME_CLKS); end
        n_cmp++; if (fs_a !== 3) begin n_err++; $display("FAIL frame_count_a: got %0d expected 3", fs_a); end
        n_cmp++; if (fs_b !== (3 * A_FRAME_CLKS + 5) / B_FRAME_CLKS) begin n_err++; $display("FAIL frame_count_b: got %0d expected %0d", fs_b, (3 * A_FRAME_CLKS + 5) / B_FRAME_CLKS); end
    endtask

    task automatic test_enable_drop();
        int wait_clks = 0;
        @(negedge clk) en = 1'b0;
        @(negedge clk) en = 1'b1;
        repeat (100) @(negedge clk);
        en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_cmp++; if (act0 !== exp_a(0)) begin n_err++; $display("FAIL en_low_a: got %h expected %h", act0, exp_a(0)); end
            n_cmp++; if (act1 !== exp_b(0)) begin n_err++; $display("FAIL en_low_b: got %h expected %h", act1, exp_b(0)); end
            n_cmp++; if ({if0.draw_x, if0.draw_y, if0.vga_hs, if0.vga_vs, if0.frame_start} !== {20'd0, 3'b110}) begin n_err++; $display("FAIL en_low_origin_a: got x=%0d y=%0d hs=%b vs=%b fs=%b expected origin/inactive", if0.draw_x, if0.draw_y, if0.vga_hs, if0.vga_vs, if0.frame_start); end
        end
        en = 1'b1;
        while (wait_clks < 2 * A_FRAME_CLKS) begin
            @(negedge clk);
            wait_clks++;
            n_cmp++; if (act0 !== exp_a(k)) begin n_err++; $display("FAIL reenable_a c=%0d: got %h expected %h", wait_clks, act0, exp_a(k)); end
            if (if0.frame_start === 1'b1) break;
        end
        n_cmp++; if (wait_clks !== A_FRAME_CLKS) begin n_err++; $display("FAIL reenable_frame_gap: got %0d expected %0d", wait_clks, A_FRAME_CLKS); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    en = 1'b1;
                    repeat ($urandom_range(1, 400)) begin
                        @(negedge clk);
                        n_cmp++; if (act0 !== exp_a(k)) begin n_err++; $display("FAIL rand_run_a k=%0d: got %h expected %h", k, act0, exp_a(k)); end
                        n_cmp++; if (act1 !== exp_b(k)) begin n_err++; $display("FAIL rand_run_b k=%0d: got %h expected %h", k, act1, exp_b(k)); end
                    end
                end
                2: begin
                    en = 1'b0;
                    repeat ($urandom_range(1, 6)) begin
                        @(negedge clk);
                        n_cmp++; if (act0 !== exp_a(k)) begin n_err++; $display("FAIL rand_off_a: got %h expected %h", act0, exp_a(k)); end
                        n_cmp++; if (act1 !== exp_b(k)) begin n_err++; $display("FAIL rand_off_b: got %h expected %h", act1, exp_b(k)); end
                    end
                    en = 1'b1;
                end
                default: begin
                    @(negedge clk);
                    #($urandom_range(1, 3)) rst = 1'b1;
                    #1;
                    n_cmp++; if (act0 !== exp_a(0)) begin n_err++; $display("FAIL async_rst_a: got %h expected %h", act0, exp_a(0)); end
                    n_cmp++; if (act1 !== exp_b(0)) begin n_err++; $display("FAIL async_rst_b: got %h expected %h", act1, exp_b(0)); end
                    @(negedge clk);
                    #2 rst = 1'b0;
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_first_pix();
        test_frame();
        test_enable_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
